// File: rtl/run_controller.sv
// run_controller: debounced run/step front panel driving a core clock enable with PC breakpoint and retired-instruction count.
module run_controller_deb #(
    parameter int DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);
    localparam int CW = $clog2(DEB_CYCLES + 1);
    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync <= '0;
            cnt  <= '0;
            dout <= 1'b0;
        end else begin
            sync <= {sync[0], din};
            if (sync[1] == dout)
                cnt <= '0;
            else if (cnt == CW'(DEB_CYCLES - 1)) begin
                dout <= sync[1];
                cnt  <= '0;
            end else
                cnt <= cnt + 1'b1;
        end
    end
endmodule

module run_controller #(
    parameter int DEB_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sw_run,
    input  logic        btn_step,
    input  logic        bp_enable,
    input  logic [31:0] bp_addr,
    input  logic [31:0] pc_address,
    input  logic        count_clr,
    output logic        core_en,
    output logic [1:0]  state,
    output logic        bp_hit,
    output logic [31:0] instr_count
);
    typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, STEP = 2'b10, BRK = 2'b11} state_t;
    state_t st, st_nxt;
    logic   run_f, step_f, step_prev, step_pulse, armed, match;

    run_controller_deb #(.DEB_CYCLES(DEB_CYCLES)) u_run_deb  (.clk(clk), .rst(rst), .din(sw_run),   .dout(run_f));
    run_controller_deb #(.DEB_CYCLES(DEB_CYCLES)) u_step_deb (.clk(clk), .rst(rst), .din(btn_step), .dout(step_f));

    assign step_pulse = step_f && !step_prev;
    assign match      = bp_enable && armed && (pc_address == bp_addr);
    assign core_en    = (st == STEP) || (st == RUN && !match);
    assign state      = st;
    assign bp_hit     = (st == BRK);

    always_comb begin
        st_nxt = st;
        case (st)
            IDLE:    st_nxt = run_f ? RUN : step_pulse ? STEP : IDLE;
            STEP:    st_nxt = run_f ? RUN : IDLE;
            RUN:     st_nxt = match ? BRK : run_f ? RUN : IDLE;
            default: st_nxt = step_pulse ? STEP : run_f ? BRK : IDLE;
        endcase
    end

    // armed is held low outside RUN so every entry to RUN starts disarmed
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st          <= IDLE;
            armed       <= 1'b0;
            step_prev   <= 1'b0;
            instr_count <= '0;
        end else begin
            st          <= st_nxt;
            armed       <= (st == RUN) && (armed || core_en);
            step_prev   <= step_f;
            instr_count <= count_clr ? '0 : instr_count + {31'b0, core_en};
        end
    end
endmodule

// File: tb/tb_run_controller.sv
// tb_run_controller: scenario tasks with a scoreboard queue and a simple PC model for run_controller.
module tb_run_controller;
    localparam int D = 4;
    logic        clk = 1'b0, rst = 1'b0, sw_run = 1'b0, btn_step = 1'b0;
    logic        bp_enable = 1'b0, count_clr = 1'b0, pc_load = 1'b0;
    logic [31:0] bp_addr = '0, pc_address = '0, pc_val = '0, exp;
    logic        core_en, bp_hit;
    logic [1:0]  state;
    logic [31:0] instr_count;
    logic [31:0] exp_q[$];
    int          checks = 0, errors = 0, en_cycles = 0, step_cycles = 0, brk_cycles = 0;

    run_controller #(.DEB_CYCLES(D)) dut (
        .clk(clk), .rst(rst), .sw_run(sw_run), .btn_step(btn_step),
        .bp_enable(bp_enable), .bp_addr(bp_addr), .pc_address(pc_address),
        .count_clr(count_clr), .core_en(core_en), .state(state),
        .bp_hit(bp_hit), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    // core model: one instruction retired per enabled cycle
    always @(posedge clk) begin
        if (pc_load) pc_address <= pc_val;
        else if (core_en) pc_address <= pc_address + 32'd4;
        en_cycles   <= en_cycles + (core_en ? 1 : 0);
        step_cycles <= step_cycles + (state == 2'b10 ? 1 : 0);
        brk_cycles  <= brk_cycles + (state == 2'b11 ? 1 : 0);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_state(input logic [1:0] s, input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max && !ok; i++) begin
            @(negedge clk);
            ok = (state == s);
        end
    endtask

    task automatic test_reset;
        #1;
        checks++; if (state !== 2'b00) begin errors++; $display("FAIL reset_state: got %b expected 00", state); end
        checks++; if (core_en !== 1'b0) begin errors++; $display("FAIL reset_core_en: got %b expected 0", core_en); end
        checks++; if (bp_hit !== 1'b0) begin errors++; $display("FAIL reset_bp_hit: got %b expected 0", bp_hit); end
        checks++; if (instr_count !== 32'd0) begin errors++; $display("FAIL reset_count: got %h expected 0", instr_count); end
        @(negedge clk);
        rst = 1'b1;
        tick(2 * D);
    endtask

    task automatic test_step;
        int s0, e0;
        exp_q.push_back(32'd1);
        exp_q.push_back(32'd1);
        exp_q.push_back(32'd1);
        s0 = step_cycles;
        e0 = en_cycles;
        btn_step = 1'b1;
        tick(20);
        btn_step = 1'b0;
        tick(D + 6);
        exp = exp_q.pop_front();
        checks++; if (32'(step_cycles - s0) !== exp) begin errors++; $display("FAIL step_cycles: got %0d expected %0d", step_cycles - s0, exp); end
        exp = exp_q.pop_front();
        checks++; if (32'(en_cycles - e0) !== exp) begin errors++; $display("FAIL step_en: got %0d expected %0d", en_cycles - e0, exp); end
        exp = exp_q.pop_front();
        checks++; if (instr_count !== exp) begin errors++; $display("FAIL step_count: got %h expected %h", instr_count, exp); end
        checks++; if (state !== 2'b00) begin errors++; $display("FAIL step_idle: got %b expected 00", state); end
    endtask

    task automatic test_glitch;
        int e0;
        count_clr = 1'b1;
        tick(1);
        count_clr = 1'b0;
        checks++; if (instr_count !== 32'd0) begin errors++; $display("FAIL clr_count: got %h expected 0", instr_count); end
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd0);
        e0 = en_cycles;
        btn_step = 1'b1;
        tick(3);
        btn_step = 1'b0;
        tick(D + 6);
        exp = exp_q.pop_front();
        checks++; if (32'(en_cycles - e0) !== exp) begin errors++; $display("FAIL glitch_en: got %0d expected %0d", en_cycles - e0, exp); end
        exp = exp_q.pop_front();
        checks++; if (instr_count !== exp) begin errors++; $display("FAIL glitch_count: got %h expected %h", instr_count, exp); end
    endtask

    task automatic test_breakpoint;
        bit ok;
        int b0;
        count_clr = 1'b1; pc_load = 1'b1; pc_val = 32'h0;
        bp_addr = 32'h10; bp_enable = 1'b1;
        tick(1);
        count_clr = 1'b0; pc_load = 1'b0;
        exp_q.push_back(32'd4);
        sw_run = 1'b1;
        wait_state(2'b11, 40, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_reach: got state %b expected 11", state); end
        exp = exp_q.pop_front();
        checks++; if (instr_count !== exp) begin errors++; $display("FAIL bp_count: got %h expected %h", instr_count, exp); end
        checks++; if (pc_address !== 32'h10) begin errors++; $display("FAIL bp_pc: got %h expected 10", pc_address); end
        checks++; if (bp_hit !== 1'b1 || core_en !== 1'b0) begin errors++; $display("FAIL bp_outputs: got hit=%b en=%b expected hit=1 en=0", bp_hit, core_en); end
        btn_step = 1'b1;
        wait_state(2'b10, D + 6, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_step: got state %b expected 10", state); end
        b0 = brk_cycles;
        btn_step = 1'b0;
        tick(6);
        checks++; if (state !== 2'b01 || brk_cycles !== b0) begin errors++; $display("FAIL bp_rerun: got state %b brk %0d expected 01 brk %0d", state, brk_cycles, b0); end
        checks++; if (instr_count !== (pc_address >> 2)) begin errors++; $display("FAIL bp_run_count: got %h expected %h", instr_count, pc_address >> 2); end
        sw_run = 1'b0;
        wait_state(2'b00, 20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_stop: got state %b expected 00", state); end
        tick(D + 2);
    endtask

    task automatic test_rearm;
        bit ok;
        int b0;
        pc_load = 1'b1; pc_val = 32'h20; bp_addr = 32'h20; bp_enable = 1'b1;
        tick(1);
        pc_load = 1'b0;
        b0 = brk_cycles;
        sw_run = 1'b1;
        wait_state(2'b01, 20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rearm_run: got state %b expected 01", state); end
        checks++; if (core_en !== 1'b1 || pc_address !== 32'h20) begin errors++; $display("FAIL rearm_first: got en=%b pc=%h expected en=1 pc=20", core_en, pc_address); end
        tick(3);
        checks++; if (state !== 2'b01 || brk_cycles !== b0) begin errors++; $display("FAIL rearm_nobrk: got state %b brk %0d expected 01 brk %0d", state, brk_cycles, b0); end
        pc_load = 1'b1; pc_val = 32'h20;
        tick(1);
        pc_load = 1'b0;
        checks++; if (core_en !== 1'b0 || state !== 2'b01) begin errors++; $display("FAIL rearm_match: got en=%b state=%b expected en=0 state=01", core_en, state); end
        tick(1);
        checks++; if (state !== 2'b11) begin errors++; $display("FAIL rearm_break: got %b expected 11", state); end
        sw_run = 1'b0;
        bp_enable = 1'b0;
        wait_state(2'b00, 20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rearm_stop: got state %b expected 00", state); end
        tick(D + 2);
    endtask

    task automatic test_wrap;
        bit ok;
        force dut.instr_count = 32'hFFFF_FFFF;
        #1;
        release dut.instr_count;
        tick(1);
        checks++; if (instr_count !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_hold: got %h expected ffffffff", instr_count); end
        exp_q.push_back(32'd0);
        btn_step = 1'b1;
        wait_state(2'b10, D + 6, ok);
        checks++; if (!ok) begin errors++; $display("FAIL wrap_step: got state %b expected 10", state); end
        tick(1);
        exp = exp_q.pop_front();
        checks++; if (instr_count !== exp) begin errors++; $display("FAIL wrap_count: got %h expected %h", instr_count, exp); end
        btn_step = 1'b0;
        tick(D + 4);
        sw_run = 1'b1;
        wait_state(2'b01, 20, ok);
        tick(2);
        checks++; if (!ok || core_en !== 1'b1) begin errors++; $display("FAIL clr_run: got state %b en %b expected 01 en 1", state, core_en); end
        count_clr = 1'b1;
        tick(1);
        count_clr = 1'b0;
        checks++; if (instr_count !== 32'd0) begin errors++; $display("FAIL clr_override: got %h expected 0", instr_count); end
        tick(1);
        checks++; if (instr_count !== 32'd1) begin errors++; $display("FAIL clr_resume: got %h expected 1", instr_count); end
    endtask

    task automatic test_async_reset;
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        checks++; if (core_en !== 1'b0 || state !== 2'b00) begin errors++; $display("FAIL arst_outputs: got en=%b state=%b expected en=0 state=00", core_en, state); end
        checks++; if (instr_count !== 32'd0 || bp_hit !== 1'b0) begin errors++; $display("FAIL arst_count: got cnt=%h hit=%b expected 0 0", instr_count, bp_hit); end
        @(negedge clk);
        rst = 1'b1;
        tick(2 + D);
        checks++; if (state !== 2'b00) begin errors++; $display("FAIL arst_early: got %b expected 00", state); end
        tick(1);
        checks++; if (state !== 2'b01) begin errors++; $display("FAIL arst_run: got %b expected 01", state); end
        sw_run = 1'b0;
        tick(D + 4);
    endtask

    initial begin
        test_reset();
        test_step();
        test_glitch();
        test_breakpoint();
        test_rearm();
        test_wrap();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
